fp_multiplier_2x32: RTL

IEEE-754 single-precision multiplier for the Taylor datapath. It sits directly upstream of fp_adder_2x32 and forms each series term, coefficient × power of x, before the adder accumulates it. It uses the same three-port strobe/acknowledge protocol as the adder, so output_z/output_z_stb/output_z_ack connect straight to the adder's input_b/input_b_stb/input_b_ack. It is a multi-cycle sequential FSM with no pipelining: one operation is in flight at a time.

---
 rtl/fp32_pkg.sv | 49 ++++
 rtl/mul_24x24.sv | 13 +
 rtl/fp_multiplier_2x32.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, field layout and sequencer states for the
// Taylor-datapath floating-point units.
package fp32_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned SEXP_W = 10;

  localparam logic signed [SEXP_W-1:0] EXP_BIAS  = 10'sd127;
  localparam logic signed [SEXP_W-1:0] EMIN      = -10'sd126;
  localparam logic signed [SEXP_W-1:0] EMAX      = 10'sd127;
  localparam logic signed [SEXP_W-1:0] E_DENORM  = -10'sd127;
  localparam logic signed [SEXP_W-1:0] E_SPECIAL = 10'sd128;

  localparam logic [EXP_W-1:0]  BIAS_FIELD = 8'd127;
  localparam logic [EXP_W-1:0]  INF_EXP    = 8'hFF;
  localparam logic [WORD_W-1:0] CANON_NAN  = 32'hFFC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL_CASES,
    NORMALISE_A,
    NORMALISE_B,
    MULTIPLY_0,
    MULTIPLY_1,
    NORMALISE_1,
    NORMALISE_2,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  // Biased exponent field to signed unbiased exponent.
  function automatic logic signed [SEXP_W-1:0] unbias(input logic [EXP_W-1:0] e);
    return $signed({2'b00, e}) - EXP_BIAS;
  endfunction

endpackage

// File: rtl/mul_24x24.sv
// Combinational 24x24 -> 48 unsigned mantissa multiply; isolated so a
// DSP-mapped implementation can be dropped in.
module mul_24x24
  import fp32_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] product_c
);

  assign product_c = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/fp_multiplier_2x32.sv
// Multi-cycle IEEE-754 binary32 multiplier with strobe/ack operand and
// result ports; one operation in flight, round-to-nearest-even.
module fp_multiplier_2x32
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  input  logic [WORD_W-1:0] input_b,
  input  logic              input_b_stb,
  output logic              input_b_ack,
  output logic [WORD_W-1:0] output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack
);

  state_t state, state_nxt;

  fp32_t a_q, a_nxt;
  fp32_t b_q, b_nxt;
  fp32_t z_q, z_nxt;

  logic [MANT_W-1:0] a_m, a_m_nxt;
  logic [MANT_W-1:0] b_m, b_m_nxt;
  logic [MANT_W-1:0] z_m, z_m_nxt;

  logic signed [SEXP_W-1:0] a_e, a_e_nxt;
  logic signed [SEXP_W-1:0] b_e, b_e_nxt;
  logic signed [SEXP_W-1:0] z_e, z_e_nxt;

  logic a_s, a_s_nxt;
  logic b_s, b_s_nxt;
  logic z_s, z_s_nxt;
  logic guard, guard_nxt;
  logic round_bit, round_bit_nxt;
  logic sticky, sticky_nxt;

  logic [PROD_W-1:0] product, product_nxt, product_c;

  logic              a_ack_nxt;
  logic              b_ack_nxt;
  logic              z_stb_nxt;
  logic [WORD_W-1:0] out_z_nxt;

  logic a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;

  // Operand classification on the unpacked fields.
  assign a_nan_c  = (a_e == E_SPECIAL) && (a_m != '0);
  assign b_nan_c  = (b_e == E_SPECIAL) && (b_m != '0);
  assign a_inf_c  = (a_e == E_SPECIAL) && (a_m == '0);
  assign b_inf_c  = (b_e == E_SPECIAL) && (b_m == '0);
  assign a_zero_c = (a_e == E_DENORM) && (a_m == '0);
  assign b_zero_c = (b_e == E_DENORM) && (b_m == '0);

  mul_24x24 u_mul (
    .a        (a_m),
    .b        (b_m),
    .product_c(product_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      a_q          <= '0;
      b_q          <= '0;
      z_q          <= '0;
      a_m          <= '0;
      b_m          <= '0;
      z_m          <= '0;
      a_e          <= '0;
      b_e          <= '0;
      z_e          <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      product      <= '0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
    end else begin
      state        <= state_nxt;
      a_q          <= a_nxt;
      b_q          <= b_nxt;
      z_q          <= z_nxt;
      a_m          <= a_m_nxt;
      b_m          <= b_m_nxt;
      z_m          <= z_m_nxt;
      a_e          <= a_e_nxt;
      b_e          <= b_e_nxt;
      z_e          <= z_e_nxt;
      a_s          <= a_s_nxt;
      b_s          <= b_s_nxt;
      z_s          <= z_s_nxt;
      guard        <= guard_nxt;
      round_bit    <= round_bit_nxt;
      sticky       <= sticky_nxt;
      product      <= product_nxt;
      input_a_ack  <= a_ack_nxt;
      input_b_ack  <= b_ack_nxt;
      output_z_stb <= z_stb_nxt;
      output_z     <= out_z_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a_q;
    b_nxt         = b_q;
    z_nxt         = z_q;
    a_m_nxt       = a_m;
    b_m_nxt       = b_m;
    z_m_nxt       = z_m;
    a_e_nxt       = a_e;
    b_e_nxt       = b_e;
    z_e_nxt       = z_e;
    a_s_nxt       = a_s;
    b_s_nxt       = b_s;
    z_s_nxt       = z_s;
    guard_nxt     = guard;
    round_bit_nxt = round_bit;
    sticky_nxt    = sticky;
    product_nxt   = product;
    a_ack_nxt     = input_a_ack;
    b_ack_nxt     = input_b_ack;
    z_stb_nxt     = output_z_stb;
    out_z_nxt     = output_z;

    case (state)
      GET_A: begin
        a_ack_nxt = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_nxt     = fp32_t'(input_a);
          a_ack_nxt = 1'b0;
          state_nxt = GET_B;
        end
      end

      GET_B: begin
        b_ack_nxt = 1'b1;
        if (input_b_ack && input_b_stb) begin
          b_nxt     = fp32_t'(input_b);
          b_ack_nxt = 1'b0;
          state_nxt = UNPACK;
        end
      end

      UNPACK: begin
        a_m_nxt   = {1'b0, a_q.frac};
        b_m_nxt   = {1'b0, b_q.frac};
        a_e_nxt   = unbias(a_q.exp);
        b_e_nxt   = unbias(b_q.exp);
        a_s_nxt   = a_q.sign;
        b_s_nxt   = b_q.sign;
        state_nxt = SPECIAL_CASES;
      end

      // Specials short-circuit to the output; otherwise restore hidden bits.
      SPECIAL_CASES: begin
        if (a_nan_c || b_nan_c) begin
          z_nxt     = fp32_t'(CANON_NAN);
          state_nxt = PUT_Z;
        end else if ((a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
          z_nxt     = fp32_t'(CANON_NAN);
          state_nxt = PUT_Z;
        end else if (a_inf_c || b_inf_c) begin
          z_nxt.sign = a_s ^ b_s;
          z_nxt.exp  = INF_EXP;
          z_nxt.frac = '0;
          state_nxt  = PUT_Z;
        end else if (a_zero_c || b_zero_c) begin
          z_nxt.sign = a_s ^ b_s;
          z_nxt.exp  = '0;
          z_nxt.frac = '0;
          state_nxt  = PUT_Z;
        end else begin
          if (a_e == E_DENORM) a_e_nxt = EMIN;
          else                 a_m_nxt[MANT_W-1] = 1'b1;
          if (b_e == E_DENORM) b_e_nxt = EMIN;
          else                 b_m_nxt[MANT_W-1] = 1'b1;
          state_nxt = NORMALISE_A;
        end
      end

      NORMALISE_A: begin
        if (a_m[MANT_W-1]) begin
          state_nxt = NORMALISE_B;
        end else begin
          a_m_nxt = a_m << 1;
          a_e_nxt = a_e - 10'sd1;
        end
      end

      NORMALISE_B: begin
        if (b_m[MANT_W-1]) begin
          state_nxt = MULTIPLY_0;
        end else begin
          b_m_nxt = b_m << 1;
          b_e_nxt = b_e - 10'sd1;
        end
      end

      MULTIPLY_0: begin
        z_s_nxt     = a_s ^ b_s;
        z_e_nxt     = a_e + b_e + 10'sd1;
        product_nxt = product_c;
        state_nxt   = MULTIPLY_1;
      end

      MULTIPLY_1: begin
        z_m_nxt       = product[PROD_W-1 -: MANT_W];
        guard_nxt     = product[MANT_W-1];
        round_bit_nxt = product[MANT_W-2];
        sticky_nxt    = |product[MANT_W-3:0];
        state_nxt     = NORMALISE_1;
      end

      NORMALISE_1: begin
        if (!z_m[MANT_W-1] && (z_e > EMIN)) begin
          z_m_nxt       = {z_m[MANT_W-2:0], guard};
          guard_nxt     = round_bit;
          round_bit_nxt = 1'b0;
          z_e_nxt       = z_e - 10'sd1;
        end else begin
          state_nxt = NORMALISE_2;
        end
      end

      // Denormalise results below the minimum exponent, folding lost bits into sticky.
      NORMALISE_2: begin
        if (z_e < EMIN) begin
          z_m_nxt       = z_m >> 1;
          z_e_nxt       = z_e + 10'sd1;
          guard_nxt     = z_m[0];
          round_bit_nxt = guard;
          sticky_nxt    = sticky | round_bit;
        end else begin
          state_nxt = ROUND;
        end
      end

      ROUND: begin
        if (guard && (round_bit || sticky || z_m[0])) begin
          z_m_nxt = z_m + 24'd1;
          if (z_m == 24'hFF_FFFF) z_e_nxt = z_e + 10'sd1;
        end
        state_nxt = PACK;
      end

      PACK: begin
        z_nxt.frac = z_m[FRAC_W-1:0];
        z_nxt.exp  = z_e[EXP_W-1:0] + BIAS_FIELD;
        z_nxt.sign = z_s;
        if ((z_e == EMIN) && !z_m[MANT_W-1]) z_nxt.exp = '0;
        if (z_e > EMAX) begin
          z_nxt.frac = '0;
          z_nxt.exp  = INF_EXP;
        end
        state_nxt = PUT_Z;
      end

      PUT_Z: begin
        z_stb_nxt = 1'b1;
        out_z_nxt = z_q;
        if (output_z_stb && output_z_ack) begin
          z_stb_nxt = 1'b0;
          state_nxt = GET_A;
        end
      end

      default: begin
        state_nxt = GET_A;
      end
    endcase
  end

endmodule
